// File: rtl/retire_monitor_pkg.sv
// retire_monitor_pkg: shared types for the retire-stream monitor.
// Revision 1.0
`default_nettype none

package retire_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int FLAG_LOAD  = 0;
    localparam int FLAG_STORE = 1;
    localparam int FLAG_TRAP  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_waddr;
        logic [31:0] rd_wdata;
        logic [2:0]  flags;
    } record_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/retire_fifo.sv
// retire_fifo: synchronous FIFO with flush; full+pop on the same edge accepts the push.
// Revision 1.0
`default_nettype none

module retire_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/retire_monitor.sv
// retire_monitor: run-control FSM, saturating statistics and trace FIFO for a retire stream.
// Revision 1.0
`default_nettype none

module retire_monitor
    import retire_monitor_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] TIMEOUT = 32'd40000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_retire_valid,
    input  logic [31:0] i_retire_inst,
    input  logic [31:0] i_retire_pc,
    input  logic        i_retire_trap,
    input  logic        i_retire_halt,
    input  logic [4:0]  i_retire_rd_waddr,
    input  logic [31:0] i_retire_rd_wdata,
    input  logic        i_retire_dmem_ren,
    input  logic        i_retire_dmem_wen,
    output logic        o_trace_valid,
    input  logic        i_trace_ready,
    output logic [31:0] o_trace_pc,
    output logic [31:0] o_trace_inst,
    output logic [31:0] o_trace_rd_wdata,
    output logic [4:0]  o_trace_rd_waddr,
    output logic [2:0]  o_trace_flags,
    output logic [31:0] o_cycles,
    output logic [31:0] o_retired,
    output logic [31:0] o_loads,
    output logic [31:0] o_stores,
    output logic [31:0] o_traps,
    output logic [1:0]  o_state,
    output logic        o_overflow
);

    state_t      state;
    state_t      state_next;
    logic [31:0] cycles, retired, loads, stores, traps;
    logic        overflow;
    logic        running, enter_run, accept, halting;
    logic        fifo_full, fifo_empty, pop;
    record_t     rec_in, rec_out;

    assign running   = (state == ST_RUN);
    assign enter_run = i_start && !running;
    assign accept    = running && i_retire_valid;
    assign halting   = accept && i_retire_halt;
    assign pop       = !fifo_empty && i_trace_ready;

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                // A halt on the timeout edge takes priority.
                if (halting)                         state_next = ST_HALTED;
                else if (cycles == TIMEOUT - 32'd1)  state_next = ST_TIMEOUT;
            end
            default: if (i_start)                   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || enter_run) begin
            cycles   <= '0;
            retired  <= '0;
            loads    <= '0;
            stores   <= '0;
            traps    <= '0;
            overflow <= 1'b0;
        end else if (running) begin
            cycles <= sat_inc(cycles);
            if (accept) begin
                retired <= sat_inc(retired);
                if (i_retire_dmem_ren) loads  <= sat_inc(loads);
                if (i_retire_dmem_wen) stores <= sat_inc(stores);
                if (i_retire_trap)     traps  <= sat_inc(traps);
                if (fifo_full && !pop) overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        rec_in                   = '0;
        rec_in.pc                = i_retire_pc;
        rec_in.inst              = i_retire_inst;
        rec_in.rd_waddr          = i_retire_rd_waddr;
        rec_in.rd_wdata          = i_retire_rd_wdata;
        rec_in.flags[FLAG_LOAD]  = i_retire_dmem_ren;
        rec_in.flags[FLAG_STORE] = i_retire_dmem_wen;
        rec_in.flags[FLAG_TRAP]  = i_retire_trap;
    end

    retire_fifo #(
        .WIDTH ($bits(record_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (enter_run),
        .push  (accept),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_trace_valid    = !fifo_empty;
    assign o_trace_pc       = rec_out.pc;
    assign o_trace_inst     = rec_out.inst;
    assign o_trace_rd_waddr = rec_out.rd_waddr;
    assign o_trace_rd_wdata = rec_out.rd_wdata;
    assign o_trace_flags    = rec_out.flags;
    assign o_cycles         = cycles;
    assign o_retired        = retired;
    assign o_loads          = loads;
    assign o_stores         = stores;
    assign o_traps          = traps;
    assign o_state          = state;
    assign o_overflow       = overflow;

endmodule

`default_nettype wire

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: directed scenarios plus randomized traffic checked against a queue-based model.
// Revision 1.0
`default_nettype none

module tb_retire_monitor;

    localparam int          D  = 4;
    localparam logic [31:0] TO = 32'd20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, rv, trap, halt, ren, wen, ready;
    logic [31:0] inst, pc, wd;
    logic [4:0]  wa;

    logic        t_valid, ovf;
    logic [31:0] t_pc, t_inst, t_wd, cyc, ret, lds, sts, trp;
    logic [4:0]  t_wa;
    logic [2:0]  t_fl;
    logic [1:0]  st;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    retire_monitor #(.DEPTH(D), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_retire_valid(rv), .i_retire_inst(inst), .i_retire_pc(pc),
        .i_retire_trap(trap), .i_retire_halt(halt),
        .i_retire_rd_waddr(wa), .i_retire_rd_wdata(wd),
        .i_retire_dmem_ren(ren), .i_retire_dmem_wen(wen),
        .o_trace_valid(t_valid), .i_trace_ready(ready),
        .o_trace_pc(t_pc), .o_trace_inst(t_inst), .o_trace_rd_wdata(t_wd),
        .o_trace_rd_waddr(t_wa), .o_trace_flags(t_fl),
        .o_cycles(cyc), .o_retired(ret), .o_loads(lds), .o_stores(sts),
        .o_traps(trp), .o_state(st), .o_overflow(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc, inst, wd;
        logic [4:0]  wa;
        logic [2:0]  fl;
    } rec_t;

    rec_t        m_q[$];
    rec_t        head_exp;
    int          m_state;
    logic [31:0] m_cyc, m_ret, m_lds, m_sts, m_trp;
    logic        m_ovf;

    function automatic logic [31:0] up(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model_clear();
        m_cyc = 0; m_ret = 0; m_lds = 0; m_sts = 0; m_trp = 0; m_ovf = 0;
        m_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            model_clear();
        end else begin
            if (m_q.size() > 0 && ready) void'(m_q.pop_front());
            if (m_state != 1) begin
                if (start) begin
                    m_state = 1;
                    model_clear();
                end
            end else begin
                m_cyc = up(m_cyc);
                if (rv) begin
                    m_ret = up(m_ret);
                    if (ren)  m_lds = up(m_lds);
                    if (wen)  m_sts = up(m_sts);
                    if (trap) m_trp = up(m_trp);
                    if (m_q.size() < D) m_q.push_back('{pc, inst, wd, wa, {trap, wen, ren}});
                    else                m_ovf = 1;
                end
                if (rv && halt)      m_state = 2;
                else if (m_cyc == TO) m_state = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            head_exp = (m_q.size() > 0) ? m_q[0] : '{default: 0};
            chk("state",    32'(st),      32'(m_state));
            chk("cycles",   cyc,          m_cyc);
            chk("retired",  ret,          m_ret);
            chk("loads",    lds,          m_lds);
            chk("stores",   sts,          m_sts);
            chk("traps",    trp,          m_trp);
            chk("overflow", 32'(ovf),     32'(m_ovf));
            chk("valid",    32'(t_valid), 32'(m_q.size() > 0));
            chk("head_pc",  t_pc,         head_exp.pc);
            chk("head_inst",t_inst,       head_exp.inst);
            chk("head_wd",  t_wd,         head_exp.wd);
            chk("head_wa",  32'(t_wa),    32'(head_exp.wa));
            chk("head_fl",  32'(t_fl),    32'(head_exp.fl));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        start = 0; rv = 0; trap = 0; halt = 0; ren = 0; wen = 0;
        inst = 0; pc = 0; wd = 0; wa = 0;
    endtask

    task automatic set_ret(input logic [31:0] p, input logic l, input logic s, input logic h);
        rv = 1; pc = p; inst = p ^ 32'h0000_0013; wd = ~p; wa = p[6:2];
        ren = l; wen = s; halt = h; trap = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    initial begin
        idle_in();
        ready = 0;
        repeat (2) step();
        chk("rst_state", 32'(st), 0);
        chk("rst_valid", 32'(t_valid), 0);
        chk("rst_cycles", cyc, 0);
        rst_n = 1;
        step();

        // Four retires ending in halt, then drain in order.
        pulse_start();
        set_ret(32'h0, 0, 0, 0); step();
        set_ret(32'h4, 1, 0, 0); step();
        set_ret(32'h8, 0, 1, 0); step();
        set_ret(32'hC, 0, 0, 1); step();
        idle_in();
        chk("halt_state", 32'(st), 2);
        chk("halt_retired", ret, 4);
        chk("halt_loads", lds, 1);
        chk("halt_stores", sts, 1);
        chk("halt_traps", trp, 0);
        chk("halt_cycles", cyc, 4);
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", t_pc, 32'(4 * i));
            step();
        end
        ready = 0;
        chk("drain_empty", 32'(t_valid), 0);

        // Timeout without halt; later retire ignored.
        pulse_start();
        repeat (19) step();
        chk("pre_to_state", 32'(st), 1);
        chk("pre_to_cycles", cyc, 19);
        step();
        chk("to_state", 32'(st), 3);
        chk("to_cycles", cyc, 20);
        set_ret(32'h40, 1, 1, 1); step(); idle_in();
        chk("to_ignored_ret", ret, 0);
        chk("to_ignored_valid", 32'(t_valid), 0);

        // Fill, simultaneous push/pop while full, then overflow.
        pulse_start();
        for (int i = 0; i < 4; i++) begin set_ret(32'h100 + 32'(4 * i), 0, 0, 0); step(); end
        ready = 1; set_ret(32'h200, 0, 0, 0); step(); ready = 0;
        chk("fullpp_ovf", 32'(ovf), 0);
        chk("fullpp_head", t_pc, 32'h104);
        set_ret(32'h300, 0, 0, 0); step(); idle_in();
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_retired", ret, 6);
        ready = 1;
        chk("ovf_d0", t_pc, 32'h104); step();
        chk("ovf_d1", t_pc, 32'h108); step();
        chk("ovf_d2", t_pc, 32'h10C); step();
        chk("ovf_d3", t_pc, 32'h200); step();
        chk("ovf_dempty", 32'(t_valid), 0);
        ready = 0;
        repeat (20) step();

        // Halt on the timeout edge wins; restart clears everything.
        pulse_start();
        for (int i = 0; i < 5; i++) begin set_ret(32'h500 + 32'(4 * i), 0, 0, 0); step(); end
        idle_in();
        repeat (14) step();
        set_ret(32'h600, 0, 0, 1); step(); idle_in();
        chk("hto_state", 32'(st), 2);
        chk("hto_cycles", cyc, 20);
        chk("hto_ovf", 32'(ovf), 1);
        pulse_start();
        chk("restart_state", 32'(st), 1);
        chk("restart_cycles", cyc, 0);
        chk("restart_retired", ret, 0);
        chk("restart_ovf", 32'(ovf), 0);
        chk("restart_valid", 32'(t_valid), 0);

        // Asynchronous reset mid-run.
        for (int i = 0; i < 5; i++) begin set_ret(32'h700 + 32'(4 * i), 1, 0, 0); step(); end
        idle_in();
        @(posedge clk); #2 rst_n = 0; #1;
        chk("arst_state", 32'(st), 0);
        chk("arst_valid", 32'(t_valid), 0);
        chk("arst_retired", ret, 0);
        chk("arst_loads", lds, 0);
        chk("arst_cycles", cyc, 0);
        chk("arst_pc", t_pc, 0);
        step(); rst_n = 1; step();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(0, 24) == 0);
            rv    = ($urandom_range(0, 9) < 7);
            pc    = $urandom; inst = $urandom; wd = $urandom; wa = 5'($urandom);
            trap  = ($urandom_range(0, 9) == 0);
            halt  = ($urandom_range(0, 29) == 0);
            ren   = 1'($urandom); wen = 1'($urandom);
            ready = ($urandom_range(0, 9) < 5);
            step();
        end
        idle_in();
        ready = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
